// File: rtl/prog_loader_pkg.sv
// Shared constants and state encodings for the program loader and its UART receiver.
package prog_loader_pkg;
  localparam logic [7:0] LOADER_SYNC = 8'hA5;
  localparam int         PROG_DEPTH  = 16;
  localparam int         PROG_AW     = $clog2(PROG_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} LOADER_STATE;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/mem_bus_if.sv
// CPU instruction-fetch bus: CPU drives the address, program store returns the word combinationally.
interface mem_bus_if;
  logic [3:0] addr;
  logic [7:0] data;
  modport slave  (input addr, output data);
  modport master (output addr, input data);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 receiver: byte/frame-error pulse 1 cycle after the stop-bit sample (~9.5 bit times after start edge).
// No backpressure: o_byte_vld and o_frame_err are single-cycle pulses the consumer must take.
module prog_loader_uart_rx
  import prog_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       i_rx,
  output logic       o_byte_vld,
  output logic [7:0] o_byte_dat,
  output logic       o_frame_err
);
  localparam int             CW   = $clog2(DIV);
  localparam logic [CW-1:0]  HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(DIV - 1);

  rx_state_t     r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_vld, w_vld_nxt, r_ferr, w_ferr_nxt;
  logic          w_rx, w_cnt_zero;

  assign w_rx       = r_sync[1];
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_prev  <= w_rx;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_vld   <= w_vld_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Counter runs down to zero; each zero is a mid-bit sample point.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? FULL : r_cnt - 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_vld_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = HALF;
        if (r_prev && !w_rx) w_state_nxt = RX_START;
      end
      RX_START: if (w_cnt_zero) begin
        w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        w_bit_nxt   = '0;
      end
      RX_DATA: if (w_cnt_zero) begin
        w_shift_nxt = {w_rx, r_shift[7:1]};
        w_bit_nxt   = r_bit + 1'b1;
        if (r_bit == 3'd7) w_state_nxt = RX_STOP;
      end
      RX_STOP: if (w_cnt_zero) begin
        w_state_nxt = RX_IDLE;
        w_vld_nxt   = w_rx;
        w_ferr_nxt  = !w_rx;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign o_byte_vld  = r_vld;
  assign o_byte_dat  = r_shift;
  assign o_frame_err = r_ferr;
endmodule

// File: rtl/prog_loader.sv
// 16x8 program store with UART loader; holds the CPU in reset while loading or after a failed load.
// Optional checksum byte when PROG_LOADER_CHECKSUM_EN is defined; read port is zero-latency, no backpressure.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic     clk,
  input  logic     n_reset,
  input  logic     uart_rx,
  mem_bus_if.slave mem_bus,
  output logic     cpu_n_reset,
  output logic     loading,
  output logic     load_err
);
  localparam int            DIV      = CLK_HZ / BAUD;
  localparam int            TMO_CYC  = TIMEOUT_BITS * DIV;
  localparam int            TW       = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  LOADER_STATE        r_state, w_state_nxt;
  logic [PROG_AW-1:0] r_wptr, w_wptr_nxt;
  logic [TW-1:0]      r_tmo;
  logic               r_load_err, w_err_nxt;
  logic               r_cpu_n_reset;
  logic               w_we, w_tmo_hit;
  logic               w_byte_vld, w_frame_err;
  logic [7:0]         w_byte_dat;
  logic [7:0]         r_mem [PROG_DEPTH];
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]         r_sum, w_sum_nxt;
`endif

  prog_loader_uart_rx #(.DIV(DIV)) u_rx (
    .clk         (clk),
    .n_reset     (n_reset),
    .i_rx        (uart_rx),
    .o_byte_vld  (w_byte_vld),
    .o_byte_dat  (w_byte_dat),
    .o_frame_err (w_frame_err)
  );

  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= IDLE;
      r_wptr        <= '0;
      r_tmo         <= '0;
      r_load_err    <= 1'b0;
      r_cpu_n_reset <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum         <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_wptr        <= w_wptr_nxt;
      r_tmo         <= (r_state == IDLE || w_byte_vld) ? '0 : r_tmo + 1'b1;
      r_load_err    <= w_err_nxt;
      r_cpu_n_reset <= ~(loading | r_load_err);
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum         <= w_sum_nxt;
`endif
    end
  end

  // A byte arriving on the timeout cycle is accepted rather than aborting the load.
  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_err_nxt   = r_load_err;
    w_we        = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    w_sum_nxt   = r_sum;
`endif
    unique case (r_state)
      IDLE: if (w_byte_vld && w_byte_dat == LOADER_SYNC) begin
        w_state_nxt = DATA;
        w_wptr_nxt  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_sum_nxt   = '0;
`endif
      end
      DATA: if (w_byte_vld) begin
        w_we       = 1'b1;
        w_wptr_nxt = r_wptr + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_sum_nxt  = r_sum + w_byte_dat;
        if (r_wptr == PROG_AW'(PROG_DEPTH - 1)) w_state_nxt = CHECK;
`else
        if (r_wptr == PROG_AW'(PROG_DEPTH - 1)) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b0;
        end
`endif
      end else if (w_frame_err || w_tmo_hit) begin
        w_state_nxt = IDLE;
        w_err_nxt   = 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: if (w_byte_vld) begin
        w_state_nxt = IDLE;
        w_err_nxt   = (w_byte_dat != r_sum);
      end else if (w_frame_err || w_tmo_hit) begin
        w_state_nxt = IDLE;
        w_err_nxt   = 1'b1;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Store is deliberately outside reset: a reset mid-load leaves written words in place.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr] <= w_byte_dat;
  end

  assign mem_bus.data = r_mem[mem_bus.addr];
  assign loading      = (r_state != IDLE);
  assign load_err     = r_load_err;
  assign cpu_n_reset  = r_cpu_n_reset;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader at DIV=10: good/bad loads, noise, timeout, framing error, reset mid-load.
module tb_prog_loader;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic n_reset, uart_rx, cpu_n_reset, loading, load_err;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_bus_if u_bus ();

  prog_loader #(.CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_BITS(32)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .uart_rx     (uart_rx),
    .mem_bus     (u_bus),
    .cpu_n_reset (cpu_n_reset),
    .loading     (loading),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } vec_t;
  vec_t       vt [16];
  logic [7:0] exp_mem [16];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Data bytes base..base+15 plus the checksum when that option is built in.
  task automatic send_body(input logic [7:0] base);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 16; k++) begin
      send_byte(base + 8'(k), 1'b1);
      s = s + base + 8'(k);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(s, 1'b1);
`endif
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      u_bus.addr = 4'(a);
      #1;
      chk8($sformatf("%s_mem%0d", tag, a), u_bus.data, exp_mem[a]);
    end
  endtask

  task automatic expect_idle_ok(input string tag);
    repeat (3) @(negedge clk);
    chk1({tag, "_loading"}, loading, 1'b0);
    chk1({tag, "_load_err"}, load_err, 1'b0);
    chk1({tag, "_cpu_n_reset"}, cpu_n_reset, 1'b1);
  endtask

  initial begin
    vt[0]  = '{4'h0, 8'h30}; vt[1]  = '{4'h1, 8'h31}; vt[2]  = '{4'h2, 8'h32}; vt[3]  = '{4'h3, 8'h33};
    vt[4]  = '{4'h4, 8'h34}; vt[5]  = '{4'h5, 8'h35}; vt[6]  = '{4'h6, 8'h36}; vt[7]  = '{4'h7, 8'h37};
    vt[8]  = '{4'h8, 8'h38}; vt[9]  = '{4'h9, 8'h39}; vt[10] = '{4'hA, 8'h3A}; vt[11] = '{4'hB, 8'h3B};
    vt[12] = '{4'hC, 8'h3C}; vt[13] = '{4'hD, 8'h3D}; vt[14] = '{4'hE, 8'h3E}; vt[15] = '{4'hF, 8'h3F};

    n_reset    = 1'b0;
    uart_rx    = 1'b1;
    u_bus.addr = 4'h0;
    repeat (3) @(negedge clk);
    chk1("rst_loading", loading, 1'b0);
    chk1("rst_load_err", load_err, 1'b0);
    chk1("rst_cpu_n_reset", cpu_n_reset, 1'b1);
    n_reset = 1'b1;
    repeat (5) @(negedge clk);

    // Good load with edge-exact checks of loading vs. cpu_n_reset.
    fork
      begin
        send_byte(8'hA5, 1'b1);
        send_body(8'h30);
      end
      begin
        int n;
        n = 0;
        while (!loading && n < 400) begin @(negedge clk); n++; end
        chk1("good_rise_seen", loading, 1'b1);
        chk1("good_nrst_at_rise", cpu_n_reset, 1'b1);
        @(negedge clk);
        chk1("good_nrst_after_rise", cpu_n_reset, 1'b0);
        n = 0;
        while (loading && n < 2500) begin @(negedge clk); n++; end
        chk1("good_fall_seen", loading, 1'b0);
        chk1("good_nrst_at_fall", cpu_n_reset, 1'b0);
        @(negedge clk);
        chk1("good_nrst_after_fall", cpu_n_reset, 1'b1);
        chk1("good_load_err", load_err, 1'b0);
      end
    join
    for (int i = 0; i < 16; i++) begin
      u_bus.addr = vt[i].addr;
      #1;
      chk8($sformatf("good_vec%0d", i), u_bus.data, vt[i].exp);
    end
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'h30 + 8'(k);

    // Noise in IDLE: a non-sync byte and a short glitch change nothing.
    send_byte(8'h12, 1'b1);
    chk1("noise_byte_loading", loading, 1'b0);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    chk1("noise_glitch_loading", loading, 1'b0);
    chk1("noise_cpu_n_reset", cpu_n_reset, 1'b1);
    check_mem("noise");

`ifdef PROG_LOADER_CHECKSUM_EN
    // Wrong checksum holds the CPU in reset until a good load.
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 16; k++) send_byte(8'h30 + 8'(k), 1'b1);
    send_byte(8'h79, 1'b1);
    repeat (20) @(negedge clk);
    chk1("badsum_loading", loading, 1'b0);
    chk1("badsum_load_err", load_err, 1'b1);
    chk1("badsum_cpu_n_reset", cpu_n_reset, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_body(8'h30);
    expect_idle_ok("badsum_recover");
`endif

    // Timeout: 5 data bytes then silence; abort 320 cycles after the last byte.
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h50 + 8'(k), 1'b1);
      exp_mem[k] = 8'h50 + 8'(k);
    end
    repeat (310) @(negedge clk);
    chk1("tmo_still_loading", loading, 1'b1);
    repeat (20) @(negedge clk);
    chk1("tmo_loading", loading, 1'b0);
    chk1("tmo_load_err", load_err, 1'b1);
    chk1("tmo_cpu_n_reset", cpu_n_reset, 1'b0);
    check_mem("tmo");

    send_byte(8'hA5, 1'b1);
    send_body(8'h30);
    expect_idle_ok("tmo_recover");
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'h30 + 8'(k);

    // Framing error mid-load aborts with load_err.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h61, 1'b1);
    chk1("ferr_pre_loading", loading, 1'b1);
    send_byte(8'h62, 1'b0);
    repeat (3) @(negedge clk);
    chk1("ferr_loading", loading, 1'b0);
    chk1("ferr_load_err", load_err, 1'b1);
    chk1("ferr_cpu_n_reset", cpu_n_reset, 1'b0);

    // Reset after 8 data bytes: immediate release, partial contents kept.
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 8; k++) begin
      send_byte(8'h70 + 8'(k), 1'b1);
      exp_mem[k] = 8'h70 + 8'(k);
    end
    chk1("rstmid_pre_loading", loading, 1'b1);
    n_reset = 1'b0;
    #1;
    chk1("rstmid_loading", loading, 1'b0);
    chk1("rstmid_load_err", load_err, 1'b0);
    chk1("rstmid_cpu_n_reset", cpu_n_reset, 1'b1);
    check_mem("rstmid");
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'hA5, 1'b1);
    chk1("rstmid_fresh_loading", loading, 1'b1);
    send_body(8'h30);
    expect_idle_ok("rstmid_done");
    for (int k = 0; k < 16; k++) exp_mem[k] = 8'h30 + 8'(k);
    check_mem("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program memory and serial loader for the 4-bit CPU. It holds the 16×8 program store that drives the CPU's instruction fetch. It receives a new program over a UART line and holds the CPU in reset while a load is in progress. It sits directly upstream of the CPU: it is the slave on the CPU's memory bus and the source of the CPU's reset.

## Interface
Parameters:
- CLK_HZ, 50_000_000: system clock frequency.
- BAUD, 115_200: UART bit rate. DIV = CLK_HZ/BAUD, integer-truncated; DIV ≥ 4 is required.
- TIMEOUT_BITS, 32: maximum idle gap between bytes of one load, in bit periods.

Ports:
- clk  in  1: system clock; all state updates on its rising edge.
- n_reset  in  1: asynchronous, active-low reset.
- uart_rx  in  1: serial input, 8N1, idle high; asynchronous to clk.
- mem_bus  mem_bus_if.slave  -: addr in [3:0]; data out [7:0].
- cpu_n_reset  out  1: registered active-low reset to the CPU.
- loading  out  1: a load is in progress.
- load_err  out  1: the last load failed; sticky until the next successful load or n_reset.

## Operation
- RX front end:
  - 2-FF synchronizer on uart_rx.
  - A falling edge starts a frame. The start bit is re-checked at DIV/2; if the line is high there, the glitch is dropped and the receiver returns to idle.
  - Data bits are sampled every DIV cycles, LSB first. Stop bit is sampled one DIV later.
  - Stop bit = 1: pulse byte_valid with the byte.
  - Stop bit = 0: pulse frame_err; no byte is delivered.
- Loader FSM states: IDLE, DATA, CHECK.
- IDLE:
  - A byte equal to LOADER_SYNC (0xA5) clears wptr and sum, then moves to DATA.
  - Any other byte is ignored.
- DATA:
  - Each byte is written to mem[wptr]; wptr increments and sum += byte, mod 256.
  - A byte equal to 0xA5 here is ordinary data.
  - After the byte written at wptr = 15: go to CHECK (checksum enabled) or finish successfully (checksum disabled).
- CHECK:
  - Next byte equals sum: success.
  - Otherwise: failure.
- Success: load_err ← 0; return to IDLE.
- Failure: load_err ← 1; return to IDLE.
- Abort to failure, from DATA or CHECK only:
  - frame_err.
  - No byte_valid for TIMEOUT_BITS×DIV cycles. The counter restarts at each byte_valid.
- frame_err in IDLE is ignored.
- Outputs:
  - loading = (state ≠ IDLE).
  - cpu_n_reset = ~(loading | load_err), registered.
  - A failed load keeps the CPU in reset until a good load completes.
- Read port:
  - mem_bus.data = mem[mem_bus.addr], combinational and asynchronous.
  - The CPU fetches in the same cycle it drives the address.
- Writes during a load go directly into the live array. The CPU is in reset then, so no fetch conflict exists.

## Timing
- Reset values:
  - FSM = IDLE; RX idle.
  - loading = 0, load_err = 0, cpu_n_reset = 1.
  - mem is NOT reset by n_reset; power-up contents are all 0x00.
- byte_valid is asserted 1 cycle after the stop-bit sample. The memory write happens on the same edge at which byte_valid is seen.
- loading rises on the edge that consumes the sync byte. cpu_n_reset falls 1 cycle later.
- On success, loading falls on the edge that consumes the checksum byte (or data byte 15 with checksum disabled). cpu_n_reset rises 1 cycle later, and the CPU then fetches from address 0.
- Reset mid-load:
  - Returns immediately to IDLE with cpu_n_reset = 1.
  - Words already written stay written; the remaining words keep their old contents.
  - No partial-load protection is provided.
- Simultaneous n_reset assertion and byte_valid: reset wins.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined:
  - The CHECK state exists and a load is 18 bytes: sync + 16 data + checksum.
  - load_err is set on checksum mismatch, frame error or timeout.
- Not defined:
  - No CHECK state and no sum register; a load is 17 bytes.
  - load_err is set only on frame error or timeout.

## Structure
- lib_cpu package additions:
  - LOADER_SYNC = 8'hA5.
  - PROG_DEPTH = 16.
  - typedef enum LOADER_STATE {IDLE, DATA, CHECK}.
- Sub-module uart_rx, parameterized by DIV:
  - Contains the synchronizer, bit timing, byte_valid/byte_data and frame_err.
  - It is reusable for a later host I/O link.
- prog_loader owns the FSM, timeout counter, checksum, array and output registers.

## Test plan
- Sim parameters: CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), TIMEOUT_BITS=32.
- Good load: A5, 0x30,0x31,…,0x3F, checksum 0x78.
  - Expect loading high from sync consumed until checksum consumed.
  - cpu_n_reset low over that window delayed by 1 cycle; load_err = 0.
  - mem[k] = 0x30+k for all addr 0..15.
- Bad checksum: same data, checksum 0x79.
  - Expect load_err = 1 and cpu_n_reset stays 0.
  - Then a good load → load_err = 0 and cpu_n_reset = 1.
- Noise: in IDLE send 0x12, then a 3-cycle low glitch on uart_rx.
  - Expect loading stays 0 and mem unchanged.
- Timeout: A5 + 5 data bytes, then line idle for 330 cycles.
  - Expect load_err = 1 and loading = 0.
  - mem[0..4] updated; mem[5..15] unchanged.
- Framing error: mid-load byte with stop bit = 0.
  - Expect abort to IDLE with load_err = 1.
- Reset mid-load: assert n_reset after 8 data bytes.
  - Expect immediately loading = 0, load_err = 0, cpu_n_reset = 1.
  - mem[0..7] = new values, mem[8..15] = old values.
  - After release, 0xA5 alone starts a fresh load.
